shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have one parameter: RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with requester 0 highest.
REQ-002 Port clock SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide, asynchronous and active-high.
REQ-004 Port req0_valid SHALL be an input, 1 bit wide: requester 0 presents an operation.
REQ-005 Port req0_ready SHALL be an output, 1 bit wide: requester 0's operation is accepted this cycle.
REQ-006 Port req0_data SHALL be an input, 32 bits wide: operand A for requester 0.
REQ-007 Port req0_shamt SHALL be an input, 5 bits wide: shift amount for requester 0.
REQ-008 Port req0_op SHALL be an input, 1 bit wide: 0 = shift-left-logical, 1 = shift-right-arithmetic.
REQ-009 Ports req1_valid, req1_ready, req1_data, req1_shamt and req1_op SHALL be identical to the req0_* ports, for requester 1.
REQ-010 Port rsp0_valid SHALL be an output, 1 bit wide: a one-cycle pulse meaning rsp0_result holds requester 0's result.
REQ-011 Port rsp0_result SHALL be an output, 32 bits wide: the shifted result for requester 0.
REQ-012 Ports rsp1_valid and rsp1_result SHALL be identical to rsp0_valid and rsp0_result, for requester 1.
REQ-013 Port busy SHALL be an output, 1 bit wide: high while a result is held in the output stage.

Function
REQ-014 The block SHALL contain exactly one shared 32-bit shift datapath: a 5-stage log shifter (stages of 1, 2, 4, 8 and 16), zero-fill for SLL and sign-fill for SRA.
REQ-015 Arbitration SHALL be combinational in the same cycle: at most one of req0_ready and req1_ready is high, and readyN is high only if reqN_valid is high.
REQ-016 With only one valid request, that requester SHALL be granted.
REQ-017 With both requests valid and RR_EN=1, the requester not granted most recently SHALL be granted; the last-grant pointer updates only on a grant.
REQ-018 With both requests valid and RR_EN=0, requester 0 SHALL always be granted.
REQ-019 An operation is accepted when reqN_valid and reqN_ready are both high; its operands SHALL be consumed in that cycle and not re-sampled.
REQ-020 Latency SHALL be exactly 1 cycle: an operation accepted at edge N produces rspN_valid=1 with the correct result during the cycle after edge N.
REQ-021 The result register SHALL also store the grantee ID; only the matching rspN_valid pulses, and the other rsp*_valid stays 0.
REQ-022 Throughput SHALL be one operation per cycle: back-to-back acceptances produce back-to-back response pulses.
REQ-023 rsp*_result SHALL hold its last value when no response is pulsing.
REQ-024 busy SHALL equal rsp0_valid OR rsp1_valid.
REQ-025 A requester that holds valid without grant SHALL keep its operands stable; behaviour is undefined otherwise.
REQ-026 Shift amount 0 SHALL return the operand unchanged; SRA by 31 SHALL return all copies of bit 31; SLL by 31 SHALL return {data[0], 31'b0}.

Reset
REQ-027 Asserting reset SHALL immediately clear rsp0_valid, rsp1_valid and busy to 0, rsp*_result to 0, and the last-grant pointer to requester 1, so that requester 0 wins the first tie.
REQ-028 An operation accepted in the cycle reset asserts SHALL be discarded with no response; ready outputs still follow the combinational valid inputs during reset.
REQ-029 After deassertion, the first acceptance SHALL behave exactly as from power-up.

Verification
REQ-030 Reset, then a single req0: SLL of 0x00000001 by 31 -> the next cycle rsp0_valid=1, rsp0_result=0x80000000, rsp1_valid=0.
REQ-031 A single req1: SRA of 0x80000000 by 4 -> the next cycle rsp1_result=0xF8000000; SRA of 0x7FFFFFFF by 31 -> 0x00000000.
REQ-032 With RR_EN=1, both requests valid for 4 cycles -> grants 0,1,0,1 and response pulses alternating rsp0, rsp1, rsp0, rsp1 delayed by 1 cycle.
REQ-033 With RR_EN=0, both requests valid for 3 cycles -> req1_ready stays 0 throughout, and rsp0_valid is high for 3 consecutive cycles.
REQ-034 Reset asserted mid-stream in the cycle after an acceptance -> rsp valids go to 0 asynchronously, and after release the next tie grants requester 0.
REQ-035 Shift by 0 of 0xDEADBEEF, both ops -> result 0xDEADBEEF.

Source files
------------

// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester arbiter feeding one shared 32-bit log shifter;
// the result, tagged with the grantee, is registered for a 1-cycle latency.
module shift_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_shamt,
  input  logic        req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_shamt,
  input  logic        req1_op,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_result,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_result,
  output logic        busy
);
  logic        last_q, v_q, id_q;
  logic [31:0] res_q;
  logic        accept;
  logic [31:0] a;
  logic [4:0]  sh;
  logic        op;
  logic [31:0] st [6];
  // last_q=1 means requester 1 was granted most recently, so requester 0 wins a tie
  assign req0_ready = req0_valid & (~req1_valid | !RR_EN | last_q);
  assign req1_ready = req1_valid & ~req0_ready;
  assign accept = req0_ready | req1_ready;
  assign a  = req1_ready ? req1_data  : req0_data;
  assign sh = req1_ready ? req1_shamt : req0_shamt;
  assign op = req1_ready ? req1_op    : req0_op;
  assign st[0] = a;
  for (genvar i = 0; i < 5; i++) begin : g_stage
    localparam int N = 2 ** i;
    logic [31:0] sll, sra;
    assign sll = {st[i][31-N:0], {N{1'b0}}};
    assign sra = {{N{st[i][31]}}, st[i][31:N]};
    assign st[i+1] = sh[i] ? (op ? sra : sll) : st[i];
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_q    <= 1'b0;
      id_q   <= 1'b0;
      res_q  <= '0;
      last_q <= 1'b1;
    end else begin
      v_q <= accept;
      if (accept) begin
        id_q   <= req1_ready;
        res_q  <= st[5];
        last_q <= req1_ready;
      end
    end
  end
  assign rsp0_valid  = v_q & ~id_q;
  assign rsp1_valid  = v_q & id_q;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign busy        = v_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: checks a round-robin and a fixed-priority instance against a
// transaction-level model every cycle, plus hand-computed literal expectations.
module tb_shift_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic v0 = 0, v1 = 0, o0 = 0, o1 = 0;
  logic [31:0] d0 = 0, d1 = 0;
  logic [4:0]  s0 = 0, s1 = 0;
  logic        r0 [2], r1 [2], rv0 [2], rv1 [2], bz [2];
  logic [31:0] res0 [2], res1 [2];
  int total = 0, bad = 0;
  bit          m_last [2], m_v [2], m_id [2];
  logic [31:0] m_res [2];

  always #5 clk = ~clk;

  shift_arbiter #(.RR_EN(1'b1)) u_rr (
    .clock(clk), .reset(rst),
    .req0_valid(v0), .req0_ready(r0[0]), .req0_data(d0), .req0_shamt(s0), .req0_op(o0),
    .req1_valid(v1), .req1_ready(r1[0]), .req1_data(d1), .req1_shamt(s1), .req1_op(o1),
    .rsp0_valid(rv0[0]), .rsp0_result(res0[0]), .rsp1_valid(rv1[0]), .rsp1_result(res1[0]),
    .busy(bz[0]));

  shift_arbiter #(.RR_EN(1'b0)) u_fp (
    .clock(clk), .reset(rst),
    .req0_valid(v0), .req0_ready(r0[1]), .req0_data(d0), .req0_shamt(s0), .req0_op(o0),
    .req1_valid(v1), .req1_ready(r1[1]), .req1_data(d1), .req1_shamt(s1), .req1_op(o1),
    .rsp0_valid(rv0[1]), .rsp0_result(res0[1]), .rsp1_valid(rv1[1]), .rsp1_result(res1[1]),
    .busy(bz[1]));

  task automatic chk(input string n, input int k, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h expected=%h t=%0t", n, k, got, exp, $time);
    end
  endtask

  // -1: no grant; otherwise the requester that must be served
  function automatic int grant(input bit rr, input bit last, input bit a, input bit b);
    if (a && b) return rr ? (last ? 0 : 1) : 0;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] shift(input logic [31:0] d, input logic [4:0] sh, input logic op);
    logic [31:0] r;
    if (op) r = $signed(d) >>> sh;
    else r = d << sh;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_last[k] = 1; m_v[k] = 0; m_id[k] = 0; m_res[k] = 0;
      end else begin
        int g;
        g = grant(k == 0, m_last[k], v0, v1);
        m_v[k] = (g >= 0);
        if (g >= 0) begin
          m_id[k] = (g == 1);
          m_res[k] = (g == 1) ? shift(d1, s1, o1) : shift(d0, s0, o0);
          m_last[k] = (g == 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int g;
      g = grant(k == 0, m_last[k], v0, v1);
      chk("ready0", k, r0[k], g == 0);
      chk("ready1", k, r1[k], g == 1);
      chk("rsp0_valid", k, rv0[k], m_v[k] && !m_id[k]);
      chk("rsp1_valid", k, rv1[k], m_v[k] && m_id[k]);
      chk("busy", k, bz[k], m_v[k]);
      if (m_v[k]) chk("result", k, m_id[k] ? res1[k] : res0[k], m_res[k]);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step; step;
    chk("reset_result", 0, res0[0], 32'h0);
    chk("reset_busy", 0, bz[0], 0);
    rst = 0;
    v0 = 1; d0 = 32'h1; s0 = 31; o0 = 0;
    step;
    v0 = 0;
    chk("sll31_valid", 0, rv0[0], 1);
    chk("sll31_result", 0, res0[0], 32'h8000_0000);
    chk("sll31_other", 0, rv1[0], 0);
    v1 = 1; d1 = 32'h8000_0000; s1 = 4; o1 = 1;
    step;
    chk("sra4_result", 0, res1[0], 32'hF800_0000);
    d1 = 32'h7FFF_FFFF; s1 = 31;
    step;
    chk("sra31_result", 0, res1[0], 32'h0);
    v1 = 0;
    step;
    v0 = 1; v1 = 1; o0 = 0; o1 = 1; s0 = 3; s1 = 2;
    for (int i = 0; i < 4; i++) begin
      d0 = 32'h100 + i; d1 = 32'hF000_0000 + i;
      #1;
      chk("rr_grant0", 0, r0[0], (i % 2) == 0);
      chk("fp_ready1", 1, r1[1], 0);
      step;
      chk("rr_rsp0", 0, rv0[0], (i % 2) == 0);
      chk("rr_rsp1", 0, rv1[0], (i % 2) == 1);
      chk("fp_rsp0", 1, rv0[1], 1);
    end
    v1 = 0; d0 = 32'hDEAD_BEEF; s0 = 0; o0 = 0;
    step;
    chk("sll0", 0, res0[0], 32'hDEAD_BEEF);
    o0 = 1;
    step;
    chk("sra0", 0, res0[0], 32'hDEAD_BEEF);
    d0 = 32'h5; s0 = 1; o0 = 0; v1 = 1;
    step;
    rst = 1;
    #1;
    chk("arst_rsp0", 0, rv0[0], 0);
    chk("arst_busy", 0, bz[0], 0);
    chk("arst_result", 0, res0[0], 32'h0);
    chk("arst_ready0", 0, r0[0], 1);
    step;
    rst = 0;
    #1;
    chk("post_tie_ready0", 0, r0[0], 1);
    step;
    chk("post_rsp0", 0, rv0[0], 1);
    chk("post_result", 0, res0[0], 32'hA);
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      d0 = $urandom; d1 = $urandom;
      s0 = 5'($urandom); s1 = 5'($urandom);
      o0 = 1'($urandom); o1 = 1'($urandom);
      step;
    end
    v0 = 0; v1 = 0;
    step; step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
